// File: rtl/s208_z_rate_meter.sv
// ============================================================================
// Module   : s208_z_rate_meter
// Counts Z-high enabled cycles over a programmable window; valid/ready result.
// Revision : 1.0
// ============================================================================
`default_nettype none

module s208_z_rate_meter #(
  parameter int CNT_W = 10,
  parameter int WIN_W = 10
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             z_in,
  input  logic             en,
  input  logic             start,
  input  logic             stop,
  input  logic             cont,
  input  logic [WIN_W-1:0] win_len,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [CNT_W-1:0] m_count,
  output logic             m_sat,
  output logic             m_lost,
  output logic             busy
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   acc_q, acc_d;
  logic               sat_q, sat_d;
  logic [WIN_W-1:0]   win_rem_q, win_rem_d;
  logic               cont_q, cont_d;
  logic               m_valid_q, m_valid_d;
  logic [CNT_W-1:0]   m_count_q, m_count_d;
  logic               m_sat_q, m_sat_d;
  logic               m_lost_q, m_lost_d;

  logic               w_sat_hit;
  logic [CNT_W-1:0]   w_acc_nxt;
  logic               w_sat_nxt;

  assign w_sat_hit = z_in && (acc_q == C_CNT_MAX);
  assign w_acc_nxt = w_sat_hit ? C_CNT_MAX : (acc_q + CNT_W'(z_in));
  assign w_sat_nxt = sat_q | w_sat_hit;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    sat_d     = sat_q;
    win_rem_d = win_rem_q;
    cont_d    = cont_q;
    m_count_d = m_count_q;
    m_sat_d   = m_sat_q;
    m_lost_d  = m_lost_q;
    // A transfer empties the slot unless a new result loads below.
    m_valid_d = m_valid_q & ~m_ready;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_RUN;
          acc_d     = '0;
          sat_d     = 1'b0;
          win_rem_d = win_len;
          cont_d    = cont;
          m_lost_d  = 1'b0;
        end
      end
      S_RUN: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (en) begin
          if (win_rem_q != '0) begin
            win_rem_d = win_rem_q - 1'b1;
            acc_d     = w_acc_nxt;
            sat_d     = w_sat_nxt;
          end else begin
            if (!m_valid_q || m_ready) begin
              m_count_d = w_acc_nxt;
              m_sat_d   = w_sat_nxt;
              m_valid_d = 1'b1;
            end else begin
              m_lost_d  = 1'b1;
            end
            // Continuous mode rearms on the same edge, so no enabled cycle is missed.
            if (cont_q) begin
              acc_d     = '0;
              sat_d     = 1'b0;
              win_rem_d = win_len;
            end else begin
              state_d   = S_IDLE;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      sat_q     <= 1'b0;
      win_rem_q <= '0;
      cont_q    <= 1'b0;
      m_valid_q <= 1'b0;
      m_count_q <= '0;
      m_sat_q   <= 1'b0;
      m_lost_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      sat_q     <= sat_d;
      win_rem_q <= win_rem_d;
      cont_q    <= cont_d;
      m_valid_q <= m_valid_d;
      m_count_q <= m_count_d;
      m_sat_q   <= m_sat_d;
      m_lost_q  <= m_lost_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_count = m_count_q;
  assign m_sat   = m_sat_q;
  assign m_lost  = m_lost_q;
  assign busy    = (state_q == S_RUN);

endmodule

`default_nettype wire
